// File: rtl/alu_pipe.sv
// Handshaked, parametrised ALU with a held output register, status flags and a
// multi-cycle restoring divider (one quotient bit per clock, MSB first).
module alu_pipe #(
    parameter int N   = 8,
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic [OPW-1:0] op,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   result,
    output logic           flag_zero,
    output logic           flag_carry,
    output logic           flag_ovf,
    output logic           flag_dz,
    output logic           busy
);
    localparam int CW = $clog2(N);

    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] OP_MUL = OPW'(2);
    localparam logic [OPW-1:0] OP_DIV = OPW'(3);
    localparam logic [OPW-1:0] OP_SHL = OPW'(4);
    localparam logic [OPW-1:0] OP_SHR = OPW'(5);
    localparam logic [OPW-1:0] OP_ROL = OPW'(6);
    localparam logic [OPW-1:0] OP_ROR = OPW'(7);

    typedef enum logic {IDLE, DIV} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [N-1:0]    rem;
    logic [N-1:0]    quo;
    logic [N-1:0]    dvs;

    logic            accept;
    logic            start_div;
    logic [N-1:0]    alu_res;
    logic            alu_carry;
    logic            alu_ovf;
    logic            alu_dz;
    logic [N:0]      sum;
    logic [N:0]      diff;
    logic [2*N-1:0]  prod;
    logic [N:0]      trial;
    logic            trial_ge;
    logic [N-1:0]    next_rem;
    logic [N-1:0]    next_quo;

    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign start_div = (op == OP_DIV) && (b != '0);
    assign busy      = (state == DIV);

    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        prod      = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_dz    = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res   = sum[N-1:0];
                alu_carry = sum[N];
                alu_ovf   = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_SUB: begin
                alu_res   = diff[N-1:0];
                alu_carry = diff[N];
                alu_ovf   = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
            end
            OP_MUL: begin
                alu_res   = prod[N-1:0];
                alu_carry = |prod[2*N-1:N];
            end
            // Only reached with b == 0; nonzero divisors go to the iterative path.
            OP_DIV: begin
                alu_res = '1;
                alu_dz  = 1'b1;
            end
            OP_SHL: begin
                alu_res   = {a[N-2:0], 1'b0};
                alu_carry = a[N-1];
            end
            OP_SHR: begin
                alu_res   = {1'b0, a[N-1:1]};
                alu_carry = a[0];
            end
            OP_ROL:  alu_res = {a[N-2:0], a[N-1]};
            OP_ROR:  alu_res = {a[0], a[N-1:1]};
            default: alu_res = '0;
        endcase
    end

    // Restoring step: shift the next dividend bit into the partial remainder.
    always_comb begin
        trial    = {rem, quo[N-1]};
        trial_ge = (trial >= {1'b0, dvs});
        next_rem = trial_ge ? N'(trial - {1'b0, dvs}) : trial[N-1:0];
        next_quo = {quo[N-2:0], trial_ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            rem        <= '0;
            quo        <= '0;
            dvs        <= '0;
            out_valid  <= 1'b0;
            result     <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            flag_ovf   <= 1'b0;
            flag_dz    <= 1'b0;
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept && start_div) begin
                        state <= DIV;
                        count <= '0;
                        rem   <= '0;
                        quo   <= a;
                        dvs   <= b;
                    end else if (accept) begin
                        out_valid  <= 1'b1;
                        result     <= alu_res;
                        flag_zero  <= (alu_res == '0);
                        flag_carry <= alu_carry;
                        flag_ovf   <= alu_ovf;
                        flag_dz    <= alu_dz;
                    end
                end
                // The output register is guaranteed empty here, so completion may load it freely.
                DIV: begin
                    rem   <= next_rem;
                    quo   <= next_quo;
                    count <= count + CW'(1);
                    if (count == CW'(N-1)) begin
                        state      <= IDLE;
                        out_valid  <= 1'b1;
                        result     <= next_quo;
                        flag_zero  <= (next_quo == '0);
                        flag_carry <= 1'b0;
                        flag_ovf   <= 1'b0;
                        flag_dz    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus randomized traffic
// checked against an integer-arithmetic reference model and an in-order scoreboard.
module tb_alu_pipe;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         flag_zero;
    logic         flag_carry;
    logic         flag_ovf;
    logic         flag_dz;
    logic         busy;
    logic [11:0]  out_bundle;

    int testsRun  = 0;
    int failCount = 0;
    logic [11:0] expQ[$];

    always #5 clk = ~clk;

    assign out_bundle = {result, flag_zero, flag_carry, flag_ovf, flag_dz};

    alu_pipe #(.N(N), .OPW(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_zero(flag_zero), .flag_carry(flag_carry),
        .flag_ovf(flag_ovf), .flag_dz(flag_dz), .busy(busy)
    );

    // Reference model: {result, zero, carry, ovf, dz} from plain integer arithmetic.
    function automatic logic [11:0] refAlu(input logic [7:0] ra, input logic [7:0] rb, input logic [2:0] rop);
        int ia, ib, sa, sb, r, s;
        logic c, v, dz;
        ia = int'(ra);
        ib = int'(rb);
        sa = (ia >= 128) ? ia - 256 : ia;
        sb = (ib >= 128) ? ib - 256 : ib;
        r = 0; c = 1'b0; v = 1'b0; dz = 1'b0;
        case (rop)
            3'd0: begin s = ia + ib; r = s % 256; c = (s > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            3'd1: begin r = (ia - ib + 256) % 256; c = (ia < ib); v = (sa - sb > 127) || (sa - sb < -128); end
            3'd2: begin s = ia * ib; r = s % 256; c = (s > 255); end
            3'd3: begin if (ib == 0) begin r = 255; dz = 1'b1; end else r = ia / ib; end
            3'd4: begin r = (ia * 2) % 256; c = (ia >= 128); end
            3'd5: begin r = ia / 2; c = (ia % 2 == 1); end
            3'd6: r = (ia * 2) % 256 + ia / 128;
            default: r = ia / 2 + (ia % 2) * 128;
        endcase
        return {8'(r), (r == 0), c, v, dz};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expectOut(input string tag, input logic [11:0] expected);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput(tag, 32'(out_bundle), 32'(expected));
    endtask

    // Present one operation and hold it until the accept edge has passed.
    task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] top);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        a = ta;
        b = tb;
        op = top;
        #1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (in_ready) done = 1'b1;
            tick();
        end
        if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit held;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
        tick(); tick();
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_bundle", 32'(out_bundle), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

        applyStimulus(8'hFF, 8'h01, 3'd0);
        expectOut("add_ff_01", {8'h00, 4'b1100});
        applyStimulus(8'h80, 8'h01, 3'd1);
        expectOut("sub_80_01", {8'h7F, 4'b0010});
        applyStimulus(8'h03, 8'h05, 3'd1);
        expectOut("sub_03_05", {8'hFE, 4'b0100});

        applyStimulus(8'd200, 8'd7, 3'd3);
        checkOutput("div_busy_start", 32'(busy), 32'd1);
        checkOutput("div_in_ready_start", 32'(in_ready), 32'd0);
        in_valid = 1'b1; a = 8'd1; b = 8'd1; op = 3'd0;
        for (int k = 1; k < 8; k++) begin
            tick();
            checkOutput("div_busy_iter", 32'(busy), 32'd1);
            checkOutput("div_out_valid_iter", 32'(out_valid), 32'd0);
            checkOutput("div_in_ready_iter", 32'(in_ready), 32'd0);
        end
        tick();
        expectOut("div_200_7", {8'd28, 4'b0000});
        checkOutput("div_busy_done", 32'(busy), 32'd0);
        tick();
        in_valid = 1'b0;
        expectOut("add_after_div", {8'd2, 4'b0000});

        applyStimulus(8'd9, 8'd0, 3'd3);
        expectOut("div_by_zero", {8'hFF, 4'b0001});
        checkOutput("div_by_zero_busy", 32'(busy), 32'd0);
        applyStimulus(8'h10, 8'h10, 3'd2);
        expectOut("mul_10_10", {8'h00, 4'b1100});
        tick();
        checkOutput("drain_out_valid", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        applyStimulus(8'h81, 8'h00, 3'd4);
        expectOut("shl_81", {8'h02, 4'b0100});
        in_valid = 1'b1; a = 8'h81; b = 8'h00; op = 3'd6;
        for (int k = 0; k < 2; k++) begin
            tick();
            expectOut("shl_81_held", {8'h02, 4'b0100});
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        expectOut("rol_81", {8'h03, 4'b0000});

        applyStimulus(8'd200, 8'd7, 3'd3);
        for (int k = 0; k < 4; k++) tick();
        rst = 1'b1;
        tick();
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_bundle", 32'(out_bundle), 32'd0);
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        applyStimulus(8'd2, 8'd3, 3'd0);
        expectOut("add_2_3", {8'd5, 4'b0000});
        for (int k = 0; k < 10; k++) tick();
        checkOutput("no_stale_div", 32'(out_valid), 32'd0);

        // Randomized traffic: upstream holds a refused operation, downstream stalls at random.
        held = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!held) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a  = 8'($urandom);
                b  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
                op = 3'($urandom_range(0, 7));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) checkOutput("unexpected_output", 32'd1, 32'd0);
                else checkOutput("random_result", 32'(out_bundle), 32'(expQ.pop_front()));
            end
            if (in_valid && in_ready) expQ.push_back(refAlu(a, b, op));
            held = in_valid && !in_ready;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 40 && expQ.size() != 0; k++) begin
            #1;
            if (out_valid) checkOutput("drain_result", 32'(out_bundle), 32'(expQ.pop_front()));
            tick();
        end
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule
